pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline control for the in-order CPU. Holds one valid bit per

---
 rtl/cpu_pipe_pkg.sv | 17 +
 rtl/hazard_match.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: stage indices, the "read from regfile" forward
// encoding and the width of a forward-select field.
package cpu_pipe_pkg;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  localparam int FWD_RF = 0;

  function automatic int sel_width(input int nstage);
    return (nstage > 2) ? $clog2(nstage) : 1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority encoder for one ID source operand: finds the youngest tracked
// producer of the same register and reports its stage and any load interlock.
module hazard_match
  import cpu_pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int AW       = 5,
  parameter int FWD_EN   = 1,
  parameter int LOAD_RDY = 4,
  localparam int SELW    = sel_width(NSTAGE),
  localparam int NT      = NSTAGE - 2
) (
  input  logic [NT-1:0]    valid_i,
  input  logic [NT-1:0]    wen_i,
  input  logic [NT-1:0]    load_i,
  input  logic [NT*AW-1:0] dst_i,
  input  logic             used_i,
  input  logic [AW-1:0]    src_i,
  output logic [SELW-1:0]  fwd_sel_o,
  output logic             stall_req_o
);

  logic [NT-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_match
      assign match[gi] = used_i & valid_i[gi] & wen_i[gi]
                       & (dst_i[gi*AW +: AW] != '0)
                       & (dst_i[gi*AW +: AW] == src_i);
    end
  endgenerate

  // Scan oldest to youngest so the lowest stage index is the one left standing.
  always_comb begin
    fwd_sel_o   = SELW'(FWD_RF);
    stall_req_o = 1'b0;
    for (int j = NT - 1; j >= 0; j--) begin
      if (match[j]) begin
        if (FWD_EN != 0) begin
          fwd_sel_o   = SELW'(j + ST_EX);
          stall_req_o = load_i[j] && ((j + ST_EX) < LOAD_RDY);
        end else begin
          fwd_sel_o   = SELW'(FWD_RF);
          stall_req_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline control: per-stage valid bits, valid/allowin/ready_go
// handshake, destination tracking for EX..WB, forwarding selects and interlock.
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int FWD_EN   = 1,
  parameter int LOAD_RDY = 4,
  parameter int CNT_W    = 32,
  localparam int SELW    = sel_width(NSTAGE)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    fs_valid_in,
  input  logic [NSTAGE-1:0]       ready_go,
  input  logic [NSTAGE-1:0]       flush_mask,
  input  logic [NUM_SRC*AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic [AW-1:0]           id_dst,
  input  logic                    id_wen,
  input  logic                    id_is_load,
  output logic [NSTAGE-1:0]       stage_valid,
  output logic [NSTAGE-1:0]       allowin,
  output logic [NSTAGE-1:0]       advance,
  output logic                    hazard_stall,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int NT = NSTAGE - 2;

  logic [NSTAGE-1:0]       valid_q, valid_d;
  logic [NT-1:0]           wen_q, wen_d, load_q, load_d;
  logic [NT*AW-1:0]        dst_q, dst_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NSTAGE-1:0]       go;
  logic [NSTAGE-1:0]       incoming;
  logic                    eval;
  logic [NUM_SRC-1:0]      stall_req;
  logic [NUM_SRC*SELW-1:0] sel_raw;
  logic [NT-1:0]           wen_src, load_src;
  logic [NT*AW-1:0]        dst_src;

  assign eval = valid_q[ST_ID] & ~flush_mask[ST_ID];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      hazard_match #(
        .NSTAGE  (NSTAGE),
        .AW      (AW),
        .FWD_EN  (FWD_EN),
        .LOAD_RDY(LOAD_RDY)
      ) u_match (
        .valid_i    (valid_q[NSTAGE-1:ST_EX]),
        .wen_i      (wen_q),
        .load_i     (load_q),
        .dst_i      (dst_q),
        .used_i     (id_src_used[gi]),
        .src_i      (id_src_addr[gi*AW +: AW]),
        .fwd_sel_o  (sel_raw[gi*SELW +: SELW]),
        .stall_req_o(stall_req[gi])
      );
    end

    // EX takes its metadata from the ID inputs; later stages from their predecessor.
    for (gi = 0; gi < NT; gi++) begin : g_meta_src
      if (gi == 0) begin : g_from_id
        assign dst_src[AW-1:0] = id_dst;
        assign wen_src[0]      = id_wen;
        assign load_src[0]     = id_is_load;
      end else begin : g_from_prev
        assign dst_src[gi*AW +: AW] = dst_q[(gi-1)*AW +: AW];
        assign wen_src[gi]          = wen_q[gi-1];
        assign load_src[gi]         = load_q[gi-1];
      end
    end
  endgenerate

  assign hazard_stall = eval & (|stall_req);
  assign fwd_sel      = eval ? sel_raw : '0;

  always_comb begin
    go        = ready_go;
    go[ST_ID] = ready_go[ST_ID] & ~hazard_stall;
  end

  // Walk from WB back to IF; "down" is the allowin of the next stage.
  always_comb begin
    logic down;
    down    = 1'b1;
    allowin = '0;
    advance = '0;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      allowin[s] = ~valid_q[s] | (go[s] & down);
      advance[s] = valid_q[s] & go[s] & down;
      down       = allowin[s];
    end
  end

  assign incoming = {advance[NSTAGE-2:0], fs_valid_in};

  always_comb begin
    valid_d = valid_q;
    for (int s = 0; s < NSTAGE; s++) begin
      if (flush_mask[s])   valid_d[s] = 1'b0;
      else if (allowin[s]) valid_d[s] = incoming[s];
    end
  end

  always_comb begin
    dst_d  = dst_q;
    wen_d  = wen_q;
    load_d = load_q;
    for (int j = 0; j < NT; j++) begin
      if (flush_mask[j+ST_EX] || (allowin[j+ST_EX] && !incoming[j+ST_EX])) begin
        dst_d[j*AW +: AW] = '0;
        wen_d[j]          = 1'b0;
        load_d[j]         = 1'b0;
      end else if (allowin[j+ST_EX]) begin
        dst_d[j*AW +: AW] = dst_src[j*AW +: AW];
        wen_d[j]          = wen_src[j];
        load_d[j]         = load_src[j];
      end
    end
  end

  assign cnt_d = cnt_q + CNT_W'(hazard_stall);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      dst_q   <= '0;
      wen_q   <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stage_valid = valid_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: forwarding and no-forwarding builds side by side,
// directed fill / load-use sequences, then random traffic against a stage model.
module tb_pipe_hazard_ctrl;

  localparam int NS   = 5;
  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int SELW = 3;
  localparam int LRDY = 4;
  localparam int CW   = 32;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 fs_valid_in = 1'b0;
  logic [NS-1:0]        ready_go = '1;
  logic [NS-1:0]        flush_mask = '0;
  logic [NSRC*AW-1:0]   id_src_addr = '0;
  logic [NSRC-1:0]      id_src_used = '0;
  logic [AW-1:0]        id_dst = '0;
  logic                 id_wen = 1'b0;
  logic                 id_is_load = 1'b0;

  logic [NS-1:0]        sv_f, al_f, ad_f, sv_n, al_n, ad_n;
  logic                 hs_f, hs_n;
  logic [NSRC*SELW-1:0] fs_f, fs_n;
  logic [CW-1:0]        cnt_f, cnt_n;

  int n_cmp, n_err, cyc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGE(NS), .AW(AW), .NUM_SRC(NSRC), .FWD_EN(1),
                     .LOAD_RDY(LRDY), .CNT_W(CW)) dut_f (
    .clk(clk), .resetn(resetn), .fs_valid_in(fs_valid_in), .ready_go(ready_go),
    .flush_mask(flush_mask), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load),
    .stage_valid(sv_f), .allowin(al_f), .advance(ad_f), .hazard_stall(hs_f),
    .fwd_sel(fs_f), .stall_cnt(cnt_f));

  pipe_hazard_ctrl #(.NSTAGE(NS), .AW(AW), .NUM_SRC(NSRC), .FWD_EN(0),
                     .LOAD_RDY(LRDY), .CNT_W(CW)) dut_n (
    .clk(clk), .resetn(resetn), .fs_valid_in(fs_valid_in), .ready_go(ready_go),
    .flush_mask(flush_mask), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load),
    .stage_valid(sv_n), .allowin(al_n), .advance(ad_n), .hazard_stall(hs_n),
    .fwd_sel(fs_n), .stall_cnt(cnt_n));

  // Model: m=0 has a bypass network, m=1 stalls on every RAW match.
  bit              mv   [2][NS];
  int              mdst [2][NS];
  bit              mwen [2][NS];
  bit              mld  [2][NS];
  logic [CW-1:0]   mcnt [2];
  logic [NS-1:0]   e_allow [2];
  logic [NS-1:0]   e_adv   [2];
  bit              e_stall [2];
  logic [NSRC*SELW-1:0] e_fwd [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < NS; s++) begin
        mv[m][s] = 0; mdst[m][s] = 0; mwen[m][s] = 0; mld[m][s] = 0;
      end
      mcnt[m] = '0;
    end
  endtask

  task automatic model_comb(input int m);
    bit eval, down, g;
    int src, hit;
    eval = mv[m][1] && !flush_mask[1];
    e_stall[m] = 0;
    e_fwd[m]   = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = int'(id_src_addr[i*AW +: AW]);
      hit = 0;
      // Youngest in-flight writer of this register, if any.
      for (int k = 2; k < NS; k++) begin
        if (hit == 0 && id_src_used[i] && mv[m][k] && mwen[m][k] &&
            mdst[m][k] != 0 && mdst[m][k] == src)
          hit = k;
      end
      if (eval && hit != 0) begin
        if (m == 0) begin
          e_fwd[m][i*SELW +: SELW] = SELW'(hit);
          if (mld[m][hit] && hit < LRDY) e_stall[m] = 1;
        end else begin
          e_stall[m] = 1;
        end
      end
    end
    down = 1;
    for (int s = NS - 1; s >= 0; s--) begin
      g = ready_go[s] && !(s == 1 && e_stall[m]);
      e_allow[m][s] = !mv[m][s] || (g && down);
      e_adv[m][s]   = mv[m][s] && g && down;
      down = e_allow[m][s];
    end
  endtask

  task automatic model_seq(input int m);
    bit ov[NS]; int od[NS]; bit ow[NS]; bit ol[NS];
    bit inc;
    for (int s = 0; s < NS; s++) begin
      ov[s] = mv[m][s]; od[s] = mdst[m][s]; ow[s] = mwen[m][s]; ol[s] = mld[m][s];
    end
    for (int s = 0; s < NS; s++) begin
      if (flush_mask[s]) begin
        mv[m][s] = 0; mdst[m][s] = 0; mwen[m][s] = 0; mld[m][s] = 0;
      end else if (e_allow[m][s]) begin
        if (s == 0) inc = fs_valid_in;
        else        inc = e_adv[m][s-1];
        mv[m][s] = inc;
        if (s >= 2) begin
          if (!inc) begin
            mdst[m][s] = 0; mwen[m][s] = 0; mld[m][s] = 0;
          end else if (s == 2) begin
            mdst[m][s] = int'(id_dst); mwen[m][s] = id_wen; mld[m][s] = id_is_load;
          end else begin
            mdst[m][s] = od[s-1]; mwen[m][s] = ow[s-1]; mld[m][s] = ol[s-1];
          end
        end
      end else begin
        mv[m][s] = ov[s];
      end
    end
    mcnt[m] = mcnt[m] + CW'(e_stall[m]);
  endtask

  task automatic cmp_dut(input int m, input string nm,
                         input logic [NS-1:0] sv, input logic [NS-1:0] al,
                         input logic [NS-1:0] ad, input logic hs,
                         input logic [NSRC*SELW-1:0] fs, input logic [CW-1:0] cnt);
    logic [NS-1:0] ev;
    for (int s = 0; s < NS; s++) ev[s] = mv[m][s];
    check({nm, ".valid"},   64'(sv),  64'(ev));
    check({nm, ".allowin"}, 64'(al),  64'(e_allow[m]));
    check({nm, ".advance"}, 64'(ad),  64'(e_adv[m]));
    check({nm, ".stall"},   64'(hs),  64'(e_stall[m]));
    check({nm, ".fwd_sel"}, 64'(fs),  64'(e_fwd[m]));
    check({nm, ".cnt"},     64'(cnt), 64'(mcnt[m]));
  endtask

  task automatic tick();
    #1;
    model_comb(0);
    model_comb(1);
    cmp_dut(0, "fwd", sv_f, al_f, ad_f, hs_f, fs_f, cnt_f);
    cmp_dut(1, "nofwd", sv_n, al_n, ad_n, hs_n, fs_n, cnt_n);
    $display("cyc %0d rg=%b fl=%b v=%b/%b adv=%b/%b hs=%b/%b fwd=%h cnt=%0d/%0d",
             cyc, ready_go, flush_mask, sv_f, sv_n, ad_f, ad_n, hs_f, hs_n, fs_f,
             cnt_f, cnt_n);
    @(posedge clk);
    model_seq(0);
    model_seq(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst.valid",   64'(sv_f),  64'(0));
    check("rst.allowin", 64'(al_f),  64'(5'b11111));
    check("rst.advance", 64'(ad_f),  64'(0));
    check("rst.stall",   64'(hs_f),  64'(0));
    check("rst.fwd_sel", 64'(fs_f),  64'(0));
    check("rst.cnt",     64'(cnt_f), 64'(0));
    check("rst.n_valid", 64'(sv_n),  64'(0));
    check("rst.n_cnt",   64'(cnt_n), 64'(0));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    model_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    resetn = 1'b1;

    // Fill: one new instruction per cycle, nothing stalls.
    fs_valid_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("fill.valid", 64'(sv_f), 64'((1 << c) - 1));
      if (c == 5) begin
        check("fill.advance", 64'(ad_f), 64'(5'b11111));
        check("fill.cnt", 64'(cnt_f), 64'(0));
      end
      tick();
    end

    // Load-use: lw $5 in ID, then a consumer of $5.
    id_dst = 5'd5; id_wen = 1'b1; id_is_load = 1'b1;
    tick();
    id_dst = 5'd0; id_wen = 1'b0; id_is_load = 1'b0;
    id_src_addr = 10'd5; id_src_used = 2'b01;
    #1;
    check("lu.stall_ex", 64'(hs_f), 64'(1));
    check("lu.sel_ex", 64'(fs_f), 64'(2));
    tick();
    #1;
    check("lu.stall_mem", 64'(hs_f), 64'(1));
    check("lu.bubble", 64'(sv_f[2]), 64'(0));
    tick();
    #1;
    check("lu.stall_wb", 64'(hs_f), 64'(0));
    check("lu.sel_wb", 64'(fs_f), 64'(4));
    check("lu.cnt", 64'(cnt_f), 64'(2));
    tick();
    id_src_used = 2'b00;

    // Random traffic with a reset dropped in mid-stream.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        #3 resetn = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
      end
      fs_valid_in = ($urandom_range(0, 99) < 85);
      for (int s = 0; s < NS; s++) begin
        ready_go[s]   = ($urandom_range(0, 99) < 85);
        flush_mask[s] = ($urandom_range(0, 99) < 4);
      end
      for (int i = 0; i < NSRC; i++)
        id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
      id_src_used = NSRC'($urandom_range(0, 3));
      id_dst      = AW'($urandom_range(0, 3));
      id_wen      = ($urandom_range(0, 99) < 70);
      id_is_load  = ($urandom_range(0, 99) < 35);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
